// File: rtl/sl_transmitter.sv
// sl_transmitter: SL two-wire serial link transmitter.
// Sends N data bits LSB first, then odd parity, then a stop symbol.
module sl_transmitter #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_done,
  output logic        tx_err,
  output logic        sl0,
  output logic        sl1
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] P_LD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] G_LD = 8'(GAP_LEN - 1);

  state_t      state, state_n;
  logic        gap, gap_n;
  logic [7:0]  timer, timer_n;
  logic [5:0]  bit_cnt, bit_cnt_n;
  logic [5:0]  last_bit, last_bit_n;
  logic [31:0] shreg, shreg_n;
  logic        par, par_n;
  logic        sl0_n, sl1_n;
  logic        done_n, err_n;
  logic [31:0] data_m;
  logic [5:0]  last_m;

  assign tx_ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gap      <= 1'b0;
      timer    <= 8'd0;
      bit_cnt  <= 6'd0;
      last_bit <= 6'd0;
      shreg    <= 32'd0;
      par      <= 1'b0;
      sl0      <= 1'b1;
      sl1      <= 1'b1;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state    <= state_n;
      gap      <= gap_n;
      timer    <= timer_n;
      bit_cnt  <= bit_cnt_n;
      last_bit <= last_bit_n;
      shreg    <= shreg_n;
      par      <= par_n;
      sl0      <= sl0_n;
      sl1      <= sl1_n;
      tx_done  <= done_n;
      tx_err   <= err_n;
    end
  end

  // Mask the word to its length so parity ignores unused bits
  always_comb begin
    data_m = 32'd0;
    last_m = 6'd0;
    unique case (mode)
      2'd0: begin
        data_m = {24'd0, tx_data[7:0]};
        last_m = 6'd7;
      end
      2'd1: begin
        data_m = {16'd0, tx_data[15:0]};
        last_m = 6'd15;
      end
      2'd2: begin
        data_m = tx_data;
        last_m = 6'd31;
      end
      2'd3: begin
        data_m = 32'd0;
        last_m = 6'd0;
      end
    endcase
  end

  always_comb begin
    state_n    = state;
    gap_n      = gap;
    timer_n    = timer;
    bit_cnt_n  = bit_cnt;
    last_bit_n = last_bit;
    shreg_n    = shreg;
    par_n      = par;
    sl0_n      = sl0;
    sl1_n      = sl1;
    done_n     = 1'b0;
    err_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          if (mode == 2'd3) begin
            err_n = 1'b1;
          end else begin
            state_n    = DATA;
            gap_n      = 1'b0;
            timer_n    = P_LD;
            bit_cnt_n  = 6'd0;
            last_bit_n = last_m;
            shreg_n    = data_m;
            par_n      = ~^data_m;
            sl0_n      = data_m[0];
            sl1_n      = ~data_m[0];
          end
        end
      end
      default: begin
        if (timer != 8'd0) begin
          timer_n = timer - 8'd1;
        end else if (!gap) begin
          gap_n   = 1'b1;
          timer_n = G_LD;
          sl0_n   = 1'b1;
          sl1_n   = 1'b1;
        end else begin
          gap_n   = 1'b0;
          timer_n = P_LD;
          unique case (state)
            DATA: begin
              if (bit_cnt == last_bit) begin
                state_n = PARITY;
                sl0_n   = par;
                sl1_n   = ~par;
              end else begin
                shreg_n   = shreg >> 1;
                bit_cnt_n = bit_cnt + 6'd1;
                sl0_n     = shreg[1];
                sl1_n     = ~shreg[1];
              end
            end
            PARITY: begin
              state_n = STOP;
              sl0_n   = 1'b0;
              sl1_n   = 1'b0;
            end
            default: begin
              state_n = IDLE;
              timer_n = 8'd0;
              done_n  = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter: directed bench for sl_transmitter.
// A line-level receiver model decodes frames from both instances.
module tb_sl_transmitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  a_mode = 2'd0;
  logic [31:0] a_data = 32'd0;
  logic        a_valid = 1'b0;
  logic        a_ready, a_done, a_err, a_sl0, a_sl1;
  logic [1:0]  b_mode = 2'd0;
  logic [31:0] b_data = 32'd0;
  logic        b_valid = 1'b0;
  logic        b_ready, b_done, b_err, b_sl0, b_sl1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sl_transmitter u_a (
    .clk(clk), .reset(reset), .mode(a_mode),
    .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .tx_done(a_done),
    .tx_err(a_err), .sl0(a_sl0), .sl1(a_sl1)
  );

  sl_transmitter #(.PULSE_LEN(1), .GAP_LEN(1)) u_b (
    .clk(clk), .reset(reset), .mode(b_mode),
    .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .tx_done(b_done),
    .tx_err(b_err), .sl0(b_sl0), .sl1(b_sl1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] bits;
    int nsym;
    int ones;
    int run;
    bit in_low;
    bit stop;
    bit bad;
    int first;
    int dones;
    logic [31:0] word;
    int last_nsym;
    bit last_par;
    int last_len;
    bit last_ok;
  } mon_t;

  mon_t m0, m1;

  function automatic mon_t clr(mon_t m);
    mon_t r = m;
    r.bits = 64'd0; r.nsym = 0; r.ones = 0;
    r.run = 0; r.in_low = 0; r.stop = 0; r.bad = 0;
    return r;
  endfunction

  function automatic mon_t step(mon_t m, logic rst,
                                logic s0, logic s1,
                                logic done, int c, int plen);
    mon_t r = m;
    logic [63:0] msk;
    if (rst) return clr(r);
    if (!(s0 && s1)) begin
      if (!r.in_low) begin
        if (r.stop) r.bad = 1;
        if (r.nsym == 0) r.first = c;
        r.in_low = 1;
        r.run = 0;
        if (!s0 && !s1) r.stop = 1;
        else begin
          r.bits[r.nsym[5:0]] = !s1;
          r.ones += int'(!s1);
          r.nsym++;
        end
      end
      r.run++;
    end else if (r.in_low) begin
      r.in_low = 0;
      if (r.run != plen) r.bad = 1;
    end
    if (done) begin
      r.dones++;
      r.last_len = c - r.first;
      r.last_nsym = r.nsym;
      if (r.nsym > 0) begin
        msk = (64'd1 << (r.nsym - 1)) - 64'd1;
        r.word = 32'(r.bits & msk);
        r.last_par = r.bits[6'(r.nsym - 1)];
      end else begin
        r.word = 32'd0;
        r.last_par = 0;
      end
      r.last_ok = r.stop && !r.bad && r.ones[0];
      r = clr(r);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    m0 = step(m0, reset, a_sl0, a_sl1, a_done, cyc, 4);
    m1 = step(m1, reset, b_sl0, b_sl1, b_done, cyc, 1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [1:0] md,
                        input logic [31:0] d);
    @(negedge clk);
    a_mode = md;
    a_data = d;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic wait_frame(input bit fast, input int budget);
    int d0 = fast ? m1.dones : m0.dones;
    int n = 0;
    while (((fast ? m1.dones : m0.dones) == d0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("frame_timeout",
        64'((fast ? m1.dones : m0.dones) != d0), 64'd1);
  endtask

  task automatic chk_frame(input string tag, input mon_t m,
                           input logic [31:0] w, input int ns,
                           input bit p, input int len);
    chk({tag, "_word"}, 64'(m.word), 64'(w));
    chk({tag, "_nsym"}, 64'(m.last_nsym), 64'(ns));
    chk({tag, "_par"}, 64'(m.last_par), 64'(p));
    chk({tag, "_len"}, 64'(m.last_len), 64'(len));
    chk({tag, "_ok"}, 64'(m.last_ok), 64'd1);
  endtask

  initial begin
    int d;
    int n;
    m0 = '{default: 0};
    m1 = '{default: 0};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sl", 64'({a_sl0, a_sl1}), 64'h3);
    chk("rst_ready", 64'(a_ready), 64'd1);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send_a(2'd0, 32'h0000_00A5);
    chk("a5_first", 64'({a_sl0, a_sl1}), 64'h2);
    chk("a5_busy", 64'(a_ready), 64'd0);
    wait_frame(0, 200);
    chk_frame("a5", m0, 32'hA5, 9, 1'b1, 80);

    send_a(2'd1, 32'hFFFF_0001);
    wait_frame(0, 300);
    chk_frame("m1", m0, 32'h0001, 17, 1'b0, 144);

    @(negedge clk);
    b_mode = 2'd2;
    b_data = 32'hFFFF_FFFF;
    b_valid = 1'b1;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    chk("ff_first", 64'({b_sl0, b_sl1}), 64'h2);
    wait_frame(1, 200);
    chk_frame("ff", m1, 32'hFFFF_FFFF, 33, 1'b1, 68);

    send_a(2'd3, 32'h0000_00FF);
    chk("ill_err", 64'(a_err), 64'd1);
    chk("ill_ready", 64'(a_ready), 64'd1);
    chk("ill_sl", 64'({a_sl0, a_sl1}), 64'h3);
    @(posedge clk);
    #1;
    chk("ill_err_clr", 64'(a_err), 64'd0);
    chk("ill_sl2", 64'({a_sl0, a_sl1}), 64'h3);
    send_a(2'd0, 32'h0000_005A);
    chk("legal_busy", 64'(a_ready), 64'd0);
    wait_frame(0, 200);
    chk_frame("5a", m0, 32'h5A, 9, 1'b1, 80);

    send_a(2'd0, 32'h0000_003C);
    a_valid = 1'b1;
    a_data = 32'h0000_00C3;
    chk("b2b_busy", 64'(a_ready), 64'd0);
    n = 0;
    while (!a_done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_done", 64'(a_done), 64'd1);
    chk("b2b_ready", 64'(a_ready), 64'd1);
    @(negedge clk);
    #1;
    chk_frame("3c", m0, 32'h3C, 9, 1'b1, 80);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    chk("b2b_acc", 64'(a_ready), 64'd0);
    chk("b2b_first", 64'({a_sl0, a_sl1}), 64'h2);
    wait_frame(0, 200);
    chk_frame("c3", m0, 32'hC3, 9, 1'b1, 80);

    send_a(2'd2, 32'hDEAD_BEEF);
    repeat (41) @(posedge clk);
    #1;
    chk("rst_bit5", 64'({a_sl0, a_sl1}), 64'h2);
    d = m0.dones;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_sl", 64'({a_sl0, a_sl1}), 64'h3);
    chk("rst_mid_ready", 64'(a_ready), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("rst_no_done", 64'(m0.dones), 64'(d));
    chk("rst_idle_sl", 64'({a_sl0, a_sl1}), 64'h3);
    send_a(2'd2, 32'h1234_5678);
    chk("post_first", 64'({a_sl0, a_sl1}), 64'h1);
    wait_frame(0, 400);
    chk_frame("post", m0, 32'h1234_5678, 33, 1'b0, 272);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
